// File: rtl/gpio_pkg.sv
// Shared register-map constants for the bus-mapped GPIO port.
package gpio_pkg;
   localparam int GPIO_ADDR_W = 3;

   localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_OUT   = 3'd0;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_DIR   = 3'd1;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_IN    = 3'd2;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_IEN   = 3'd3;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_IPOL  = 3'd4;
   localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_IPEND = 3'd5;
endpackage

// File: rtl/gpio_port_io_sync.sv
// Multi-stage flop synchroniser for the asynchronous pin inputs; the last stage is the output.
module io_sync #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   logic [WIDTH-1:0] stage [SYNC_STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[SYNC_STAGES-1];
endmodule

// File: rtl/gpio_port.sv
// Parametrised bidirectional I/O port: per-bit direction, synchronised inputs,
// per-bit edge interrupts with enable, polarity and write-1-to-clear pending bits.
module gpio_port
   import gpio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   sel_i,
   input  logic                   wr_i,
   input  logic                   rd_i,
   input  logic [GPIO_ADDR_W-1:0] addr_i,
   input  logic [WIDTH-1:0]       int_data_i,
   output logic [WIDTH-1:0]       int_data_o,
   inout  wire logic [WIDTH-1:0]  ext_data_io,
   output logic                   irq_o
);
   logic [WIDTH-1:0] port_out;
   logic [WIDTH-1:0] port_dir;
   logic [WIDTH-1:0] int_en;
   logic [WIDTH-1:0] int_pol;
   logic [WIDTH-1:0] int_pend;
   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] in_prev;
   logic [WIDTH-1:0] edge_ev;
   logic [WIDTH-1:0] pend_clr;
   logic             wr_en;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign ext_data_io[i] = port_dir[i] ? port_out[i] : 1'bz;
   end

   // Driven pins are sensed too, so IN always shows the real pin level.
   io_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_io_sync (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .din   (ext_data_io),
      .dout  (in_sync)
   );

   assign wr_en    = wr_i & sel_i;
   assign edge_ev  = (int_pol & in_sync & ~in_prev) | (~int_pol & ~in_sync & in_prev);
   assign pend_clr = (wr_en && addr_i == GPIO_ADDR_IPEND) ? int_data_i : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         port_out <= '0;
         port_dir <= '0;
         int_en   <= '0;
         int_pol  <= '0;
         int_pend <= '0;
         in_prev  <= '0;
      end else begin
         in_prev  <= in_sync;
         // A new event overrides a simultaneous write-1-to-clear.
         int_pend <= (int_pend & ~pend_clr) | (edge_ev & int_en);
         if (wr_en) begin
            case (addr_i)
               GPIO_ADDR_OUT:  port_out <= int_data_i;
               GPIO_ADDR_DIR:  port_dir <= int_data_i;
               GPIO_ADDR_IEN:  int_en   <= int_data_i;
               GPIO_ADDR_IPOL: int_pol  <= int_data_i;
               default:        ;
            endcase
         end
      end
   end

   always_comb begin
      int_data_o = '0;
      if (rd_i && sel_i) begin
         case (addr_i)
            GPIO_ADDR_OUT:   int_data_o = port_out;
            GPIO_ADDR_DIR:   int_data_o = port_dir;
            GPIO_ADDR_IN:    int_data_o = in_sync;
            GPIO_ADDR_IEN:   int_data_o = int_en;
            GPIO_ADDR_IPOL:  int_data_o = int_pol;
            GPIO_ADDR_IPEND: int_data_o = int_pend;
            default:         int_data_o = '0;
         endcase
      end
   end

   assign irq_o = |(int_pend & int_en);
endmodule

// File: tb/tb_gpio_port.sv
// Randomised and directed bench for gpio_port with a queue scoreboard and a pin-history model.
`timescale 1ns/1ps
module tb_gpio_port;
   import gpio_pkg::*;

   localparam int W  = 8;
   localparam int S  = 2;
   localparam int W2 = 16;
   localparam int S2 = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sel = 1'b0, wr = 1'b0, rd = 1'b0;
   logic [2:0]    addr = 3'd0;
   logic [W-1:0]  wdata = '0;
   logic [W-1:0]  rdata;
   wire  [W-1:0]  ext;
   logic          irq;
   logic [W-1:0]  pin_val = '0;

   logic          sel2 = 1'b0, wr2 = 1'b0, rd2 = 1'b0;
   logic [2:0]    addr2 = 3'd0;
   logic [W2-1:0] wdata2 = '0;
   logic [W2-1:0] rdata2;
   wire  [W2-1:0] ext2;
   logic          irq2;
   logic [W2-1:0] pin2_val = '0;

   // Reference model state
   logic [W-1:0]  m_out = '0, m_dir = '0, m_ien = '0, m_ipol = '0, m_ipend = '0;
   logic [W-1:0]  hist[$];
   logic [W-1:0]  exp_q[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < W; i++) begin : g_drv
      assign ext[i] = m_dir[i] ? 1'bz : pin_val[i];
   end
   assign ext2 = pin2_val;

   gpio_port #(.WIDTH(W), .SYNC_STAGES(S)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .wr_i(wr), .rd_i(rd), .addr_i(addr),
      .int_data_i(wdata), .int_data_o(rdata), .ext_data_io(ext), .irq_o(irq));

   gpio_port #(.WIDTH(W2), .SYNC_STAGES(S2)) u_dut16 (
      .clk_i(clk), .rst_ni(rst_n), .sel_i(sel2), .wr_i(wr2), .rd_i(rd2), .addr_i(addr2),
      .int_data_i(wdata2), .int_data_o(rdata2), .ext_data_io(ext2), .irq_o(irq2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // hist holds the last S+1 pin samples, newest last: IN is the sample S edges old.
   task automatic m_reset();
      m_out = '0; m_dir = '0; m_ien = '0; m_ipol = '0; m_ipend = '0;
      hist.delete();
      repeat (S + 1) hist.push_back('0);
   endtask

   function automatic logic [W-1:0] m_in();
      return hist[hist.size() - S];
   endfunction

   function automatic logic [W-1:0] m_prev();
      return hist[hist.size() - S - 1];
   endfunction

   function automatic logic [W-1:0] m_read(input logic [2:0] a);
      case (a)
         GPIO_ADDR_OUT:   return m_out;
         GPIO_ADDR_DIR:   return m_dir;
         GPIO_ADDR_IN:    return m_in();
         GPIO_ADDR_IEN:   return m_ien;
         GPIO_ADDR_IPOL:  return m_ipol;
         GPIO_ADDR_IPEND: return m_ipend;
         default:         return '0;
      endcase
   endfunction

   task automatic tick();
      logic [W-1:0] pin_now, cur, old, set, clr;
      @(posedge clk);
      #1;
      pin_now = (m_dir & m_out) | (~m_dir & pin_val);
      cur = m_in();
      old = m_prev();
      set = '0;
      for (int i = 0; i < W; i++) begin
         if (m_ien[i]) set[i] = m_ipol[i] ? (cur[i] && !old[i]) : (!cur[i] && old[i]);
      end
      clr = '0;
      if (sel && wr) begin
         case (addr)
            GPIO_ADDR_OUT:   m_out  = wdata;
            GPIO_ADDR_DIR:   m_dir  = wdata;
            GPIO_ADDR_IEN:   m_ien  = wdata;
            GPIO_ADDR_IPOL:  m_ipol = wdata;
            GPIO_ADDR_IPEND: clr    = wdata;
            default: ;
         endcase
      end
      m_ipend = (m_ipend & ~clr) | set;
      hist.push_back(pin_now);
      void'(hist.pop_front());
   endtask

   task automatic cycle(input logic s, input logic w, input logic r, input logic [2:0] a,
                        input logic [W-1:0] d);
      sel = s; wr = w; rd = r; addr = a; wdata = d;
      if (s && r) exp_q.push_back(m_read(a));
      tick();
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 1'b0, 1'b0, 3'd0, '0);
   endtask

   task automatic wreg(input logic [2:0] a, input logic [W-1:0] d);
      cycle(1'b1, 1'b1, 1'b0, a, d);
   endtask

   task automatic rreg(input logic [2:0] a);
      cycle(1'b1, 1'b0, 1'b1, a, '0);
   endtask

   // Monitor: reads are popped from the scoreboard; irq and pins checked every cycle.
   always @(negedge clk) begin
      if (sel && rd) begin
         if (exp_q.size() == 0) chk("rd_unexpected", 32'(rdata), 32'hFFFF_FFFF);
         else chk("rd_data", 32'(rdata), 32'(exp_q.pop_front()));
      end else begin
         chk("rd_idle_zero", 32'(rdata), 32'h0);
      end
      chk("irq", 32'(irq), 32'(|(m_ipend & m_ien)));
      chk("pins", 32'(ext), 32'((m_dir & m_out) | (~m_dir & pin_val)));
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      int lat;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      rreg(GPIO_ADDR_DIR); rreg(GPIO_ADDR_OUT); rreg(GPIO_ADDR_IEN); rreg(GPIO_ADDR_IPEND);

      wreg(GPIO_ADDR_DIR, 8'h0F);
      wreg(GPIO_ADDR_OUT, 8'hA5);
      pin_val = 8'h30;
      idle(2);
      rreg(GPIO_ADDR_IN);

      wreg(GPIO_ADDR_IEN, 8'h01);
      wreg(GPIO_ADDR_IPOL, 8'h01);
      wreg(GPIO_ADDR_DIR, 8'hF0);
      idle(3);
      pin_val[0] = 1'b1;
      idle(4);
      rreg(GPIO_ADDR_IPEND);
      wreg(GPIO_ADDR_IPEND, 8'h01);
      rreg(GPIO_ADDR_IPEND);

      // Falling edge with rising polarity must not set; then a set colliding with W1C.
      pin_val[0] = 1'b0;
      idle(4);
      rreg(GPIO_ADDR_IPEND);
      pin_val[0] = 1'b1;
      idle(2);
      wreg(GPIO_ADDR_IPEND, 8'h01);
      rreg(GPIO_ADDR_IPEND);
      wreg(GPIO_ADDR_IPEND, 8'h01);
      rreg(GPIO_ADDR_IPEND);

      wreg(GPIO_ADDR_IEN, 8'h00);
      pin_val[2] = 1'b1; idle(4);
      pin_val[2] = 1'b0; idle(4);
      rreg(GPIO_ADDR_IPEND);
      cycle(1'b1, 1'b0, 1'b0, GPIO_ADDR_OUT, '0);
      rreg(3'd6); rreg(3'd7);
      wreg(3'd6, 8'hFF); wreg(3'd7, 8'hFF);
      for (int a = 0; a < 6; a++) rreg(3'(a));
      cycle(1'b1, 1'b1, 1'b1, GPIO_ADDR_OUT, 8'h3C);
      rreg(GPIO_ADDR_OUT);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) pin_val = W'($urandom);
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), W'($urandom));
      end
      idle(2);

      // Fill IPEND via driven-pin rising edges, then reset in the middle of a write.
      wreg(GPIO_ADDR_OUT, 8'h00);
      wreg(GPIO_ADDR_DIR, 8'hFF);
      wreg(GPIO_ADDR_IPOL, 8'hFF);
      wreg(GPIO_ADDR_IEN, 8'hFF);
      wreg(GPIO_ADDR_IPEND, 8'hFF);
      idle(3);
      wreg(GPIO_ADDR_OUT, 8'hFF);
      idle(4);
      rreg(GPIO_ADDR_IPEND);
      chk("ipend_full_model", 32'(m_ipend), 32'hFF);
      sel = 1'b1; wr = 1'b1; rd = 1'b0; addr = GPIO_ADDR_OUT; wdata = 8'h5A;
      #1 rst_n = 1'b0;
      m_reset();
      #0.5;
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_pins_released", 32'(ext), 32'(pin_val));
      for (int a = 0; a < 6; a++) begin
         rd = 1'b1; addr = 3'(a);
         #0.25;
         chk("rst_read_zero", 32'(rdata), 32'h0);
      end
      rd = 1'b0; addr = GPIO_ADDR_OUT;
      @(posedge clk);
      #1;
      sel = 1'b0; wr = 1'b0; rst_n = 1'b1;
      rreg(GPIO_ADDR_OUT); rreg(GPIO_ADDR_DIR); rreg(GPIO_ADDR_IPEND);
      idle(3);
      rreg(GPIO_ADDR_IN);
      idle(2);

      // Wide instance: IN latency equals its three-stage synchroniser.
      pin2_val = 16'hBEEF;
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         sel2 = 1'b1; rd2 = 1'b1; addr2 = GPIO_ADDR_IN;
         #1;
         if (lat == 0 && rdata2 == 16'hBEEF) lat = k;
         sel2 = 1'b0; rd2 = 1'b0;
      end
      chk("w16_in_latency", 32'(lat), 32'(S2));
      #1;
      chk("w16_rd_idle_zero", 32'(rdata2), 32'h0);
      chk("w16_irq", 32'(irq2), 32'h0);

      idle(2);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/gpio_port.md
Name: gpio_port

Overview:
- Parametrised, bus-mapped bidirectional I/O port; successor to the fixed 8-bit I/O register used by the monocycle core's I/O interface.
- Adds the following over the 8-bit register:
  - configurable width;
  - per-bit direction register instead of one global direction line;
  - synchronised input sampling;
  - per-bit edge-detect interrupts with enable, polarity and write-1-to-clear pending bits.
- Sits on the core's data bus behind the address decoder (sel_i); drives/senses the external pins.

Parameters:
- WIDTH, 8, number of I/O pins and data-bus width of the port.
- SYNC_STAGES, 2, flops in the input synchroniser chain; legal values 2..4.

Ports:
- clk_i  input  1  system clock, all state updates on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- sel_i  input  1  port selected by address decoder.
- wr_i  input  1  write strobe; write occurs when wr_i & sel_i at clk_i rising edge.
- rd_i  input  1  read strobe; read data valid when rd_i & sel_i.
- addr_i  input  3  register select (map below).
- int_data_i  input  WIDTH  write data from core.
- int_data_o  output  WIDTH  read data to core, combinational.
- ext_data_io  inout  WIDTH  external pins.
- irq_o  output  1  level interrupt to core.

Behaviour:
Register map (addr_i):
- 0 OUT: output data, RW.
- 1 DIR: direction, RW; bit=1 drives pin, bit=0 high-Z.
- 2 IN: synchronised pin value, RO; writes ignored.
- 3 IEN: interrupt enable, RW.
- 4 IPOL: edge polarity, RW; 1=rising, 0=falling.
- 5 IPEND: pending, read / write-1-to-clear.
- 6..7: reserved; read 0, writes ignored.

Pins:
- ext_data_io[i] = DIR[i] ? OUT[i] : 1'bz, evaluated per bit.
- Output pins are also sensed: IN reflects the driven value after synchroniser latency.

Reset (rst_ni low, asynchronous):
- OUT, DIR, IEN, IPOL, IPEND, synchroniser flops and previous-sample register all = 0.
- All pins therefore start as inputs (high-Z); irq_o = 0.
- Reset mid-operation: state is cleared immediately, no pending write completes. Release is synchronous-safe because it relies only on register state.

Writes:
- Updated register takes int_data_i at the rising edge where wr_i & sel_i.
- New OUT/DIR value appears on the pins in the same cycle after the edge.

Reads:
- int_data_o = selected register when rd_i & sel_i, else all zeros.
- Purely combinational, zero latency.
- rd_i & wr_i together to the same address: read returns the pre-write value.

Input path:
- Each pin passes through a SYNC_STAGES flop chain; the last stage is IN.
- prev register = IN delayed one cycle.
- A pin change is visible in IN exactly SYNC_STAGES rising edges later.

Edge detect, per bit:
- ev[i] = IPOL[i] ? (IN[i] & ~prev[i]) : (~IN[i] & prev[i]).
- Set: if ev[i] & IEN[i] then IPEND[i] <= 1 on the next edge.
- Clear: write to IPEND with int_data_i[i]=1 clears bit i.
- Set and clear in the same cycle: set wins, bit stays 1.
- Events with IEN[i]=0 are discarded, not latched.
- Clearing IEN does not clear IPEND.

Interrupt:
- irq_o = |(IPEND & IEN), combinational from registers, no glitches from pins.

Width rules:
- All data registers are WIDTH bits; no sign or extension logic.
- addr_i is decoded fully; reserved decodes have no side effects.

Decomposition:
- Shared package gpio_pkg:
  - address constants GPIO_ADDR_OUT=0, DIR=1, IN=2, IEN=3, IPOL=4, IPEND=5;
  - localparam GPIO_ADDR_W=3.
- One sub-module: io_sync, a WIDTH-wide, SYNC_STAGES-deep synchroniser with async active-low reset to 0, instantiated once for the input path.
- Edge detect and register file stay in gpio_port.

Test Plan:
- Reset, then read DIR/OUT/IEN/IPEND -> all 0x00; ext_data_io all Z; irq_o=0.
- Write DIR=0x0F, OUT=0xA5 -> pins[3:0]=0x5 driven, pins[7:4]=Z. Bench drives pins[7:4]=0x3, then reads IN after 2 cycles -> 0x35.
- Set IEN=0x01, IPOL=0x01; bench raises pin0 (DIR[0]=0) -> IN[0] after 2 edges, IPEND=0x01 one edge later, irq_o=1. Write IPEND=0x01 -> IPEND=0x00, irq_o=0.
- Rising edge on pin0 in the same cycle as a W1C of IPEND bit 0 -> IPEND[0] remains 1. Falling edge with IPOL[0]=1 -> no set.
- Set IEN=0x00; toggle pin2 -> IPEND stays 0x00. Read with rd_i=0 -> int_data_o=0x00. Read addr 6 -> 0x00.
- Assert rst_ni low mid-transfer with IPEND=0xFF and DIR=0xFF -> immediately all registers 0, pins Z, irq_o=0. Repeat with WIDTH=16, SYNC_STAGES=3: IN latency 3 cycles.
